data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port readEn  input  1  CPU byte read request.
REQ-004 SHALL have port writeEn  input  1  CPU byte write request.
REQ-005 SHALL have port dataAddress  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-006 SHALL have port dataIn  input  8  CPU write data.
REQ-007 SHALL have port dataOut  output  8  CPU read data.
REQ-008 SHALL have port BUSY  output  1  CPU stall; CPU holds its request while high.
REQ-009 SHALL have port memRead  output  1  block fetch request to memory.
REQ-010 SHALL have port memWrite  output  1  block write-back request to memory.
REQ-011 SHALL have port memAddress  output  6  block address {tag,index}.
REQ-012 SHALL have port memWriteData  output  32  block to memory; byte k at bits [8k+7:8k].
REQ-013 SHALL have port memReadData  input  32  block from memory, same byte order.
REQ-014 SHALL have port memBusy  input  1  memory busy; request completes on first cycle it is sampled low.

Function
REQ-015 SHALL be direct-mapped, write-back, write-allocate: 8 lines x 4 bytes, each with valid bit, dirty bit, 3-bit tag.
REQ-016 SHALL evaluate hit combinationally: valid[index] and tag[index]==dataAddress[7:5].
REQ-017 SHALL, on a read hit in IDLE, drive dataOut with the addressed byte combinationally, with BUSY low the same cycle.
REQ-018 SHALL, on a write hit in IDLE, write dataIn into the addressed byte and set dirty at the next CLK rising edge, with BUSY low.
REQ-019 SHALL raise BUSY combinationally whenever a request misses in IDLE, and keep it high in every non-IDLE state.
REQ-020 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-021 SHALL take IDLE->WRITEBACK on a miss to a valid dirty line, and IDLE->ALLOCATE on a miss to an invalid or clean line.
REQ-022 SHALL, in WRITEBACK, drive memWrite=1, memAddress={storedTag,index}, memWriteData=line; it SHALL go to ALLOCATE once memBusy is sampled low.
REQ-023 SHALL, in ALLOCATE, drive memRead=1, memAddress=dataAddress[7:2]; it SHALL capture memReadData and go to UPDATE once memBusy is sampled low.
REQ-024 SHALL, in UPDATE, write the captured block, tag, valid=1, dirty=0 and return to IDLE, where the request is re-evaluated as a hit.
REQ-025 SHALL treat readEn and writeEn both high as a write.
REQ-026 SHALL hold memRead, memWrite and dataOut at 0 when idle or with no request.

Reset
REQ-027 SHALL, on RESET, clear all valid and dirty bits, force IDLE, and drive BUSY, memRead, memWrite and dataOut to 0.
REQ-028 SHALL, on RESET during WRITEBACK or ALLOCATE, abort the transfer without writing the line.

Configuration
REQ-029 SHALL, with DATA_CACHE_STATS_EN defined, add outputs hitCount[15:0] and missCount[15:0].
REQ-030 SHALL, under DATA_CACHE_STATS_EN, increment missCount on each IDLE exit.
REQ-031 SHALL, under DATA_CACHE_STATS_EN, increment hitCount on each first-lookup hit, excluding the re-lookup after UPDATE.
REQ-032 SHALL, under DATA_CACHE_STATS_EN, saturate both counters at 0xFFFF and clear them on RESET.
REQ-033 SHALL, without DATA_CACHE_STATS_EN, omit these ports and all counter logic.

Structure
REQ-034 SHALL place the following in shared package data_cache_pkg: state enum, line count 8, block bytes 4, tag width 3, index width 3, offset width 2.
REQ-035 SHALL implement the FSM in one sub-module, data_cache_fsm; tag/data arrays stay in data_cache.

Verification
REQ-036 SHALL cover: after reset, read 0x00 with memory 4-cycle busy, block 0x44332211 -> ALLOCATE, memAddress=0x00, BUSY high until UPDATE+1, dataOut=0x11.
REQ-037 SHALL cover: read 0x03 after the previous scenario -> hit, BUSY low, dataOut=0x44, no memRead.
REQ-038 SHALL cover: write 0x02=0xAA, then read 0x22 -> write-back to memAddress=0x00 of 0x44AA2211, then fetch memAddress=0x08.
REQ-039 SHALL cover: readEn and writeEn both high, dataIn=0x5A, address 0x01 -> write occurs, subsequent read returns 0x5A.
REQ-040 SHALL cover: RESET pulsed mid-ALLOCATE -> IDLE, BUSY=0, memRead=0; re-read 0x00 misses again.
REQ-041 SHALL cover, with DATA_CACHE_STATS_EN: scenarios REQ-036..REQ-038 -> missCount=2, hitCount=2.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared types and geometry for the direct-mapped, write-back data cache.
package data_cache_pkg;

    localparam int NUM_LINES   = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int TAG_W       = 3;
    localparam int INDEX_W     = 3;
    localparam int OFFSET_W    = 2;
    localparam int LINE_W      = 8 * BLOCK_BYTES;
    localparam int BLK_ADDR_W  = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_e;

endpackage

// File: rtl/data_cache_if.sv
// Block-level memory bus between the cache (master) and backing memory (slave).
interface data_cache_if;
    import data_cache_pkg::*;

    logic                  memRead;
    logic                  memWrite;
    logic [BLK_ADDR_W-1:0] memAddress;
    logic [LINE_W-1:0]     memWriteData;
    logic [LINE_W-1:0]     memReadData;
    logic                  memBusy;

    modport master (
        output memRead, memWrite, memAddress, memWriteData,
        input  memReadData, memBusy
    );

    modport slave (
        input  memRead, memWrite, memAddress, memWriteData,
        output memReadData, memBusy
    );

endinterface

// File: rtl/data_cache_fsm.sv
// Miss-handling controller: write back a dirty victim, fetch the block, install it.
// Drives only the memory request strobes; address and data come from the top.
module data_cache_fsm
    import data_cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               req_i,
    input  logic               hit_i,
    input  logic               victim_dirty_i,
    data_cache_if.master       mem,
    output state_e             state_o,
    output logic               busy_o
);

    state_e state_q, state_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b0;
        mem.memRead  = 1'b0;
        mem.memWrite = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i && !hit_i) begin
                    busy_o  = 1'b1;
                    state_d = victim_dirty_i ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                busy_o       = 1'b1;
                mem.memWrite = 1'b1;
                if (!mem.memBusy) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                busy_o      = 1'b1;
                mem.memRead = 1'b1;
                if (!mem.memBusy) state_d = UPDATE;
            end
            UPDATE: begin
                busy_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate byte cache: 8 lines x 4 bytes.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
    import data_cache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        readEn,
    input  logic        writeEn,
    input  logic [7:0]  dataAddress,
    input  logic [7:0]  dataIn,
    output logic [7:0]  dataOut,
    output logic        BUSY,
    output logic        memRead,
    output logic        memWrite,
    output logic [5:0]  memAddress,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    input  logic        memBusy
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0] hitCount,
    output logic [15:0] missCount
`endif
);

    logic [TAG_W-1:0]    tag_in;
    logic [INDEX_W-1:0]  idx;
    logic [OFFSET_W-1:0] off;
    logic [4:0]          bit_base;

    assign tag_in   = dataAddress[OFFSET_W+INDEX_W +: TAG_W];
    assign idx      = dataAddress[OFFSET_W +: INDEX_W];
    assign off      = dataAddress[OFFSET_W-1:0];
    assign bit_base = {off, 3'b000};

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [LINE_W-1:0]    fill_q;

    logic   req, hit, fsm_busy, idle_wr_hit;
    state_e state;

    // Both enables high is treated as a write.
    assign req         = readEn | writeEn;
    assign hit         = valid_q[idx] && (tag_q[idx] == tag_in);
    assign idle_wr_hit = (state == IDLE) && writeEn && hit;

    data_cache_if mem_bus ();

    data_cache_fsm u_fsm (
        .CLK            (CLK),
        .RESET          (RESET),
        .req_i          (req),
        .hit_i          (hit),
        .victim_dirty_i (valid_q[idx] & dirty_q[idx]),
        .mem            (mem_bus.master),
        .state_o        (state),
        .busy_o         (fsm_busy)
    );

    assign mem_bus.memReadData = memReadData;
    assign mem_bus.memBusy     = memBusy;
    assign memRead             = mem_bus.memRead;
    assign memWrite            = mem_bus.memWrite;
    assign memAddress          = mem_bus.memAddress;
    assign memWriteData        = mem_bus.memWriteData;

    always_comb begin
        mem_bus.memAddress   = '0;
        mem_bus.memWriteData = '0;
        case (state)
            WRITEBACK: begin
                mem_bus.memAddress   = {tag_q[idx], idx};
                mem_bus.memWriteData = data_q[idx];
            end
            ALLOCATE: mem_bus.memAddress = dataAddress[7:OFFSET_W];
            default: ;
        endcase
    end

    assign BUSY    = fsm_busy & ~RESET;
    assign dataOut = (!RESET && state == IDLE && readEn && !writeEn && hit)
                     ? data_q[idx][bit_base +: 8] : 8'h00;

    always_ff @(posedge CLK) begin
        if (state == ALLOCATE && !memBusy) fill_q <= memReadData;
    end

    // Tag/data payload carries no reset; valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            if (state == UPDATE) begin
                data_q[idx] <= fill_q;
                tag_q[idx]  <= tag_in;
            end else if (idle_wr_hit) begin
                data_q[idx][bit_base +: 8] <= dataIn;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state == UPDATE) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (idle_wr_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    logic        relookup_q;
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // The lookup right after UPDATE is the tail of a miss, not a fresh hit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            relookup_q <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            relookup_q <= (state == UPDATE);
            if (state == IDLE && req) begin
                if (hit && !relookup_q && hit_cnt_q != 16'hFFFF)
                    hit_cnt_q <= hit_cnt_q + 16'd1;
                if (!hit && miss_cnt_q != 16'hFFFF)
                    miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a 4-cycle-busy block memory model.
// Counter checks are included when DATA_CACHE_STATS_EN is defined.
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        readEn, writeEn;
    logic [7:0]  dataAddress, dataIn, dataOut;
    logic        BUSY;

    data_cache_if mem_bus ();

`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hitCount, missCount;
`endif

    data_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .readEn       (readEn),
        .writeEn      (writeEn),
        .dataAddress  (dataAddress),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .BUSY         (BUSY),
        .memRead      (mem_bus.memRead),
        .memWrite     (mem_bus.memWrite),
        .memAddress   (mem_bus.memAddress),
        .memWriteData (mem_bus.memWriteData),
        .memReadData  (mem_bus.memReadData),
        .memBusy      (mem_bus.memBusy)
`ifdef DATA_CACHE_STATS_EN
        ,
        .hitCount     (hitCount),
        .missCount    (missCount)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Memory model: busy for 4 sampled cycles per request, completes on the 5th.
    logic [31:0] mem [64];
    int          rd_count = 0, wr_count = 0;
    logic [5:0]  last_rd_addr, last_wr_addr;
    logic [31:0] last_wr_data;

    initial begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h44332211;
        mem[8] = 32'h88776655;
        last_rd_addr = '0;
        last_wr_addr = '0;
        last_wr_data = '0;
        mem_bus.memBusy     = 1'b0;
        mem_bus.memReadData = 32'h0;
        forever begin
            @(negedge CLK);
            if (RESET || !(mem_bus.memRead || mem_bus.memWrite)) begin
                mem_bus.memBusy = 1'b0;
                cnt = 0;
            end else if (cnt < 4) begin
                mem_bus.memBusy = 1'b1;
                cnt++;
            end else begin
                mem_bus.memBusy = 1'b0;
                cnt = 0;
                if (mem_bus.memWrite) begin
                    mem[mem_bus.memAddress] = mem_bus.memWriteData;
                    last_wr_addr = mem_bus.memAddress;
                    last_wr_data = mem_bus.memWriteData;
                    wr_count++;
                end else begin
                    mem_bus.memReadData = mem[mem_bus.memAddress];
                    last_rd_addr = mem_bus.memAddress;
                    rd_count++;
                end
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with the request dropped.
    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] din, output logic [7:0] dout, output int stall);
        readEn = rd; writeEn = wr; dataAddress = addr; dataIn = din;
        #1;
        stall = 0;
        while (BUSY && stall < 100) begin
            @(negedge CLK); #1;
            stall++;
        end
        dout = dataOut;
        @(negedge CLK);
        readEn = 1'b0; writeEn = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         s;
        int         rd_before;

        RESET = 1'b1; readEn = 1'b1; writeEn = 1'b0; dataAddress = 8'h00; dataIn = 8'h00;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy",     BUSY,             0);
        chk("rst_memread",  mem_bus.memRead,  0);
        chk("rst_memwrite", mem_bus.memWrite, 0);
        chk("rst_dataout",  dataOut,          0);
        readEn = 1'b0;
        @(negedge CLK); RESET = 1'b0;
        @(negedge CLK);

        cpu_access(1, 0, 8'h00, 8'h00, d, s);
        chk("s1_stall",   s, 7);
        chk("s1_data",    d, 8'h11);
        chk("s1_rdcount", rd_count, 1);
        chk("s1_rdaddr",  last_rd_addr, 6'h00);
        chk("s1_wrcount", wr_count, 0);

        cpu_access(1, 0, 8'h03, 8'h00, d, s);
        chk("s2_stall",   s, 0);
        chk("s2_data",    d, 8'h44);
        chk("s2_rdcount", rd_count, 1);

        cpu_access(0, 1, 8'h02, 8'hAA, d, s);
        chk("s3_wr_stall", s, 0);
        cpu_access(1, 0, 8'h22, 8'h00, d, s);
        chk("s3_stall",   s, 12);
        chk("s3_wrcount", wr_count, 1);
        chk("s3_wraddr",  last_wr_addr, 6'h00);
        chk("s3_wrdata",  last_wr_data, 32'h44AA2211);
        chk("s3_rdcount", rd_count, 2);
        chk("s3_rdaddr",  last_rd_addr, 6'h08);
        chk("s3_data",    d, 8'h77);
`ifdef DATA_CACHE_STATS_EN
        chk("stats_miss", missCount, 2);
        chk("stats_hit",  hitCount,  2);
`endif

        cpu_access(1, 1, 8'h01, 8'h5A, d, s);
        chk("s4_stall",   s, 7);
        chk("s4_rdcount", rd_count, 3);
        chk("s4_rdaddr",  last_rd_addr, 6'h00);
        chk("s4_wrcount", wr_count, 1);
        cpu_access(1, 0, 8'h01, 8'h00, d, s);
        chk("s4_rd_stall", s, 0);
        chk("s4_rd_data",  d, 8'h5A);
        cpu_access(1, 0, 8'h02, 8'h00, d, s);
        chk("s4_rd2_data", d, 8'hAA);

        rd_before = rd_count;
        readEn = 1'b1; writeEn = 1'b0; dataAddress = 8'h04;
        repeat (3) @(negedge CLK);
        #1;
        chk("s5_alloc_memread", mem_bus.memRead, 1);
        chk("s5_alloc_addr",    mem_bus.memAddress, 6'h01);
        RESET = 1'b1;
        #1;
        chk("s5_rst_busy",    BUSY, 0);
        chk("s5_rst_memread", mem_bus.memRead, 0);
        chk("s5_rst_dataout", dataOut, 0);
        readEn = 1'b0;
        @(negedge CLK); RESET = 1'b0;
        chk("s5_no_fill", rd_count, rd_before);
        cpu_access(1, 0, 8'h00, 8'h00, d, s);
        chk("s5_re_stall",   s, 7);
        chk("s5_re_rdcount", rd_count, rd_before + 1);
        chk("s5_re_data",    d, 8'h11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
